// File: rtl/alct_loopback_tester.sv
// LCT cable loopback tester: drives NCH pattern channels, compares the returned words
// against a latency-matched copy of what was sent, and keeps error/word statistics.
module alct_loopback_tester #(
    parameter  int NCH    = 4,
    parameter  int WIDTH  = 48,
    parameter  int MAXLAT = 16,
    parameter  int ERRW   = 16,
    parameter  int WCW    = 32,
    localparam int LATW   = $clog2(MAXLAT),
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int BITW   = $clog2(WIDTH)
) (
    input  logic                   i_clock_mez,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_stop,
    input  logic [1:0]             i_mode,
    input  logic [LATW-1:0]        i_lat,
    output logic [NCH*WIDTH-1:0]   o_tx_data,
    input  logic [NCH*WIDTH-1:0]   i_rx_data,
    output logic                   o_busy,
    output logic                   o_err_any,
    output logic [CHW-1:0]         o_first_err_ch,
    output logic [BITW-1:0]        o_first_err_bit,
    output logic [NCH*ERRW-1:0]    o_err_cnt,
    output logic [WCW-1:0]         o_word_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN} state_t;

    state_t                 r_state, w_next;
    logic [1:0]             r_mode;
    logic [LATW-1:0]        r_lat;
    logic [LATW-1:0]        r_fcnt;
    logic [WIDTH-1:0]       r_k;      // index of the next word to put on the cable
    logic [BITW-1:0]        r_pos;    // r_k mod WIDTH, kept separately for the walking patterns
    logic [NCH*WIDTH-1:0]   r_tx;
    logic [NCH*WIDTH-1:0]   r_dly [MAXLAT-1];
    logic                   r_err_any;
    logic [CHW-1:0]         r_fch;
    logic [BITW-1:0]        r_fbit;
    logic [NCH*ERRW-1:0]    r_err_cnt;
    logic [WCW-1:0]         r_word_cnt;

    logic [NCH*WIDTH-1:0]   w_exp;
    logic [NCH*WIDTH-1:0]   w_diff;
    logic [NCH-1:0]         w_chmis;
    logic [CHW-1:0]         w_fch;
    logic [BITW-1:0]        w_fbit;
    logic [BITW-1:0]        w_pos_next;

    function automatic logic [NCH*WIDTH-1:0] f_pattern(input logic [1:0] mode,
                                                       input logic [WIDTH-1:0] k,
                                                       input logic [BITW-1:0] pos);
        logic [NCH*WIDTH-1:0] w;
        int p;
        w = '0;
        for (int c = 0; c < NCH; c++) begin
            p = int'(pos) + c;
            if (p >= WIDTH) p = p - WIDTH;
            case (mode)
                2'd0: w[c*WIDTH +: WIDTH] = {{(WIDTH-1){1'b0}}, 1'b1} << p;
                2'd1: w[c*WIDTH +: WIDTH] = ~({{(WIDTH-1){1'b0}}, 1'b1} << p);
                2'd2: for (int i = 0; i < WIDTH; i++) w[c*WIDTH + i] = k[0] ^ i[0];
                default: w[c*WIDTH +: WIDTH] = k + WIDTH'(c);
            endcase
        end
        return w;
    endfunction

    always_ff @(posedge i_clock_mez) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_start) begin
            w_next = (i_lat != '0) ? S_FILL : S_RUN;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (i_stop)                             w_next = S_IDLE;
                    else if (r_fcnt == r_lat - LATW'(1))    w_next = S_RUN;
                end
                S_RUN:   if (i_stop) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // lat=0 compares against the word on the cable this very cycle
    assign w_exp      = (r_lat == '0) ? r_tx : r_dly[r_lat - LATW'(1)];
    assign w_diff     = i_rx_data ^ w_exp;
    assign w_pos_next = (r_pos == BITW'(WIDTH-1)) ? '0 : r_pos + BITW'(1);

    // Scan downward so the lowest mismatching channel, and its lowest bit, win
    always_comb begin
        w_chmis = '0;
        w_fch   = '0;
        w_fbit  = '0;
        for (int c = 0; c < NCH; c++) w_chmis[c] = |w_diff[c*WIDTH +: WIDTH];
        for (int c = NCH-1; c >= 0; c--) begin
            if (w_chmis[c]) begin
                w_fch = CHW'(c);
                for (int i = WIDTH-1; i >= 0; i--)
                    if (w_diff[c*WIDTH + i]) w_fbit = BITW'(i);
            end
        end
    end

    always_ff @(posedge i_clock_mez) begin
        if (i_reset) begin
            r_mode     <= '0;
            r_lat      <= '0;
            r_fcnt     <= '0;
            r_k        <= '0;
            r_pos      <= '0;
            r_tx       <= '0;
            r_err_any  <= 1'b0;
            r_fch      <= '0;
            r_fbit     <= '0;
            r_err_cnt  <= '0;
            r_word_cnt <= '0;
            for (int i = 0; i < MAXLAT-1; i++) r_dly[i] <= '0;
        end else begin
            r_dly[0] <= r_tx;
            for (int i = 1; i < MAXLAT-1; i++) r_dly[i] <= r_dly[i-1];

            if (i_start) begin
                r_mode     <= i_mode;
                r_lat      <= i_lat;
                r_fcnt     <= '0;
                r_tx       <= f_pattern(i_mode, '0, '0);
                r_k        <= WIDTH'(1);
                r_pos      <= BITW'(1 % WIDTH);
                r_err_any  <= 1'b0;
                r_fch      <= '0;
                r_fbit     <= '0;
                r_err_cnt  <= '0;
                r_word_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                if (i_stop) begin
                    r_tx <= '0;
                end else begin
                    r_tx  <= f_pattern(r_mode, r_k, r_pos);
                    r_k   <= r_k + WIDTH'(1);
                    r_pos <= w_pos_next;
                end
                if (r_state == S_FILL) r_fcnt <= r_fcnt + LATW'(1);
                // The stop cycle itself still carries a valid word and is compared
                if (r_state == S_RUN) begin
                    if (r_word_cnt != '1) r_word_cnt <= r_word_cnt + WCW'(1);
                    for (int c = 0; c < NCH; c++)
                        if (w_chmis[c] && r_err_cnt[c*ERRW +: ERRW] != '1)
                            r_err_cnt[c*ERRW +: ERRW] <= r_err_cnt[c*ERRW +: ERRW] + ERRW'(1);
                    if (!r_err_any && (|w_chmis)) begin
                        r_err_any <= 1'b1;
                        r_fch     <= w_fch;
                        r_fbit    <= w_fbit;
                    end
                end
            end
        end
    end

    assign o_tx_data       = r_tx;
    assign o_busy          = (r_state != S_IDLE);
    assign o_err_any       = r_err_any;
    assign o_first_err_ch  = r_fch;
    assign o_first_err_bit = r_fbit;
    assign o_err_cnt       = r_err_cnt;
    assign o_word_cnt      = r_word_cnt;

endmodule

// File: tb/tb_alct_loopback_tester.sv
// Directed bench for alct_loopback_tester: cable modelled as a tx history delay,
// expected tx words queued at start and popped each busy cycle.
module tb_alct_loopback_tester;

    logic         clk = 1'b0;
    logic         reset, start, stop;
    logic [1:0]   mode;
    logic [3:0]   lat;
    logic [191:0] tx, rx, rx_flip, rx_zero;
    logic         busy, err_any;
    logic [1:0]   fch;
    logic [5:0]   fbit;
    logic [63:0]  err_cnt;
    logic [31:0]  word_cnt;

    logic [191:0] s_tx;
    logic         s_busy, s_err_any;
    logic [1:0]   s_fch;
    logic [5:0]   s_fbit;
    logic [15:0]  s_err_cnt;
    logic [31:0]  s_word_cnt;

    logic [191:0] th [16];
    int           rx_dly;
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [191:0] txq [$];

    always #5 clk = ~clk;

    alct_loopback_tester u_dut (
        .i_clock_mez(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_lat(lat), .o_tx_data(tx), .i_rx_data(rx),
        .o_busy(busy), .o_err_any(err_any), .o_first_err_ch(fch),
        .o_first_err_bit(fbit), .o_err_cnt(err_cnt), .o_word_cnt(word_cnt)
    );

    alct_loopback_tester #(.ERRW(4)) u_sat (
        .i_clock_mez(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
        .i_mode(mode), .i_lat(lat), .o_tx_data(s_tx), .i_rx_data(rx_zero),
        .o_busy(s_busy), .o_err_any(s_err_any), .o_first_err_ch(s_fch),
        .o_first_err_bit(s_fbit), .o_err_cnt(s_err_cnt), .o_word_cnt(s_word_cnt)
    );

    // Cable model: th[i] holds tx from i+1 cycles ago
    always @(posedge clk) begin
        th[0] <= tx;
        for (int i = 1; i < 16; i++) th[i] <= th[i-1];
    end

    always_comb rx = ((rx_dly == 0) ? tx : th[rx_dly-1]) ^ rx_flip;

    function automatic logic [191:0] model_word(input int m, input int k);
        logic [191:0] w;
        logic [47:0]  ch;
        w = '0;
        for (int c = 0; c < 4; c++) begin
            case (m)
                0:       ch = 48'd1 << ((k + c) % 48);
                1:       ch = ~(48'd1 << ((k + c) % 48));
                2:       ch = (k % 2 == 0) ? 48'hAAAA_AAAA_AAAA : 48'h5555_5555_5555;
                default: ch = 48'(k + c);
            endcase
            w[c*48 +: 48] = ch;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int m, input int l, input int n);
        start = 1'b1;
        mode  = 2'(m);
        lat   = 4'(l);
        txq.delete();
        for (int k = 0; k < n; k++) txq.push_back(model_word(m, k));
        tick();
        start = 1'b0;
    endtask

    task automatic do_busy(input int n, input bit do_stop, input int flip_at);
        logic [191:0] e;
        for (int j = 0; j < n; j++) begin
            rx_flip = (j == flip_at) ? (192'd1 << (2*48 + 17)) : '0;
            if (txq.size() == 0) begin
                e = '1;
            end else begin
                e = txq.pop_front();
            end
            check("tx_data", tx, e);
            check("busy", 192'(busy), 192'd1);
            if (do_stop && j == n-1) stop = 1'b1;
            tick();
        end
        stop    = 1'b0;
        rx_flip = '0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = '0; lat = '0;
        rx_flip = '0; rx_zero = '0; rx_dly = 0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("rst_tx", tx, '0);
        check("rst_busy", 192'(busy), '0);
        check("rst_err_cnt", 192'(err_cnt), '0);
        check("rst_word_cnt", 192'(word_cnt), '0);
        check("rst_err_any", 192'(err_any), '0);
        check("rst_first_ch", 192'(fch), '0);
        check("rst_first_bit", 192'(fbit), '0);

        // clean walk-1 loop at matched latency
        rx_dly = 3;
        do_start(0, 3, 103);
        do_busy(103, 1, -1);
        check("t2_tx_idle", tx, '0);
        check("t2_busy", 192'(busy), '0);
        check("t2_err_cnt", 192'(err_cnt), '0);
        check("t2_word_cnt", 192'(word_cnt), 192'd100);
        check("t2_err_any", 192'(err_any), '0);

        // clean AA/55 loop
        rx_dly = 5;
        do_start(2, 5, 20);
        do_busy(20, 1, -1);
        check("t2b_err_cnt", 192'(err_cnt), '0);
        check("t2b_word_cnt", 192'(word_cnt), 192'd15);

        // cable one clock short of the programmed latency
        rx_dly = 2;
        do_start(0, 3, 53);
        do_busy(53, 1, -1);
        check("t3_err_cnt", 192'(err_cnt), 192'({4{16'd50}}));
        check("t3_word_cnt", 192'(word_cnt), 192'd50);
        check("t3_err_any", 192'(err_any), 192'd1);
        check("t3_first_ch", 192'(fch), '0);
        check("t3_first_bit", 192'(fbit), '0);

        // counter pattern, single flipped bit 17 of channel 2
        rx_dly = 0;
        do_start(3, 0, 20);
        do_busy(20, 1, 5);
        check("t4_err_cnt", 192'(err_cnt), 192'({16'd0, 16'd1, 16'd0, 16'd0}));
        check("t4_word_cnt", 192'(word_cnt), 192'd20);
        check("t4_err_any", 192'(err_any), 192'd1);
        check("t4_first_ch", 192'(fch), 192'd2);
        check("t4_first_bit", 192'(fbit), 192'd17);

        // walk-0 against grounded rx on the 4-bit-counter instance
        rx_dly = 0;
        do_start(1, 0, 40);
        do_busy(40, 1, -1);
        check("t5_sat_err_cnt", 192'(s_err_cnt), 192'(16'hFFFF));
        check("t5_sat_word_cnt", 192'(s_word_cnt), 192'd40);
        check("t5_sat_first_ch", 192'(s_fch), '0);
        check("t5_sat_first_bit", 192'(s_fbit), 192'd1);
        check("t5_err_cnt", 192'(err_cnt), '0);
        check("t5_word_cnt", 192'(word_cnt), 192'd40);

        // restart mid-RUN with a different mode and latency
        rx_dly = 1;
        do_start(0, 0, 10);
        do_busy(10, 0, -1);
        check("t6_pre_word_cnt", 192'(word_cnt), 192'd10);
        check("t6_pre_err_cnt", 192'(err_cnt), 192'({4{16'd10}}));
        rx_dly = 2;
        do_start(2, 2, 8);
        check("t6_rs_word_cnt", 192'(word_cnt), '0);
        check("t6_rs_err_cnt", 192'(err_cnt), '0);
        check("t6_rs_err_any", 192'(err_any), '0);
        do_busy(8, 1, -1);
        check("t6_rs_final_cnt", 192'(word_cnt), 192'd6);
        check("t6_rs_final_err", 192'(err_cnt), '0);

        // reset mid-RUN with errors already accumulated
        rx_dly = 0;
        do_start(3, 1, 5);
        do_busy(5, 0, -1);
        check("t6_pre_rst_any", 192'(err_any), 192'd1);
        check("t6_pre_rst_cnt", 192'(word_cnt), 192'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_tx", tx, '0);
        check("t6_rst_busy", 192'(busy), '0);
        check("t6_rst_word_cnt", 192'(word_cnt), '0);
        check("t6_rst_err_cnt", 192'(err_cnt), '0);
        check("t6_rst_err_any", 192'(err_any), '0);
        do_start(1, 0, 5);
        do_busy(5, 1, -1);
        check("t6_post_word_cnt", 192'(word_cnt), 192'd5);
        check("t6_post_err_cnt", 192'(err_cnt), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
